// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS opcode/funct encodings and write-back kinds
// Purpose: constants shared by the write-back stage and its register file.
// Ports: none (package).
package mips_defs;

    localparam int REG_AW       = 5;
    localparam int NREG_DEF     = 32;
    localparam int LINK_REG_DEF = 31;

    // Primary opcodes (Ins[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;

    // R-type function codes (Ins[5:0])
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    // What the instruction in write-back commits, if anything
    typedef enum logic [2:0] {
        WB_NONE,
        WB_GPR_WDATA,   // GPR <= Wdata
        WB_GPR_LINK,    // GPR <= nextPC
        WB_HILO,        // HI <= HI_in, LO <= LO_in
        WB_MTHI,        // HI <= Wdata
        WB_MTLO         // LO <= Wdata
    } wb_kind_e;

endpackage

// File: rtl/regfile32.sv
// rtl/regfile32.sv - general register file, 2 async read ports, 1 sync write port
// Purpose: architectural GPRs; register 0 is hardwired to zero.
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low clear
//   i_we/i_waddr/i_wdata  synchronous write port
//   i_ra1/i_ra2           read addresses
//   o_rd1/o_rd2           combinational read data (no write-through bypass)
module regfile32 #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_ra1,
    input  logic [AW-1:0] i_ra2,
    output logic [31:0]   o_rd1,
    output logic [31:0]   o_rd2
);

    logic [31:0] r_mem [NREG];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Address 0 is gated on the read side too, so $0 reads zero regardless of storage
    assign o_rd1 = (i_ra1 == '0) ? 32'h0 : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? 32'h0 : r_mem[i_ra2];

endmodule

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - MIPS write-back stage: decode destination, commit GPR and HI/LO
// Purpose: decodes the instruction leaving MA and commits its result on the rising edge.
// Ports:
//   CLK, RST                 clock, asynchronous active-low reset
//   Ins, Wdata, nextPC       instruction, MA result, link value
//   HI_in, LO_in             multiply/divide results from EX
//   Stall                    suppresses every commit this cycle
//   Ra1/Ra2, Rdata1/Rdata2   combinational register reads for ID
//   HI, LO                   architectural HI/LO
//   WB_we/WB_addr/WB_data    the GPR commit that happens at the next edge
//   Wcount                   number of GPR commits (wraps)
module wb_unit
    import mips_defs::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       Ins,
    input  logic [31:0]       Wdata,
    input  logic [31:0]       nextPC,
    input  logic [31:0]       HI_in,
    input  logic [31:0]       LO_in,
    input  logic              Stall,
    input  logic [REG_AW-1:0] Ra1,
    input  logic [REG_AW-1:0] Ra2,
    output logic [31:0]       Rdata1,
    output logic [31:0]       Rdata2,
    output logic [31:0]       HI,
    output logic [31:0]       LO,
    output logic              WB_we,
    output logic [REG_AW-1:0] WB_addr,
    output logic [31:0]       WB_data,
    output logic [31:0]       Wcount
);

    localparam logic [REG_AW-1:0] LINK_ADDR = REG_AW'(LINK_REG);

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rt;
    wb_kind_e          w_kind;
    logic [REG_AW-1:0] w_dest;
    logic              w_gpr_wr;
    logic              w_unused_fields;

    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
    logic [31:0]       r_wcount;

    assign w_op    = Ins[31:26];
    assign w_funct = Ins[5:0];
    assign w_rd    = Ins[15:11];
    assign w_rt    = Ins[20:16];

    // rs and shamt are consumed upstream; write-back never needs them
    assign w_unused_fields = ^{Ins[25:21], Ins[10:6]};

    always_comb begin
        w_kind = WB_NONE;
        w_dest = '0;
        if (w_op == OP_RTYPE) begin
            case (w_funct) inside
                FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV,
                FN_SRAV, FN_MFHI, FN_MFLO: begin
                    w_kind = WB_GPR_WDATA;
                    w_dest = w_rd;
                end
                FN_JALR: begin
                    w_kind = WB_GPR_LINK;
                    w_dest = w_rd;
                end
                [FN_MULT:FN_DIVU]: w_kind = WB_HILO;
                FN_MTHI:           w_kind = WB_MTHI;
                FN_MTLO:           w_kind = WB_MTLO;
                default:           w_kind = WB_NONE;   // JR and unknown functs
            endcase
        end else if ((w_op inside {[OP_ADDI:OP_LUI]}) || (w_op == OP_LW)) begin
            w_kind = WB_GPR_WDATA;
            w_dest = w_rt;
        end else if (w_op == OP_JAL) begin
            w_kind = WB_GPR_LINK;
            w_dest = LINK_ADDR;
        end
    end

    assign w_gpr_wr = (w_kind == WB_GPR_WDATA) || (w_kind == WB_GPR_LINK);

    // Writes to $0 are dropped here so they neither reach the file nor count
    assign WB_we   = w_gpr_wr && !Stall && (w_dest != '0);
    assign WB_addr = w_dest;
    assign WB_data = (w_kind == WB_GPR_LINK) ? nextPC : Wdata;

    regfile32 #(
        .NREG (NREG),
        .AW   (REG_AW)
    ) u_regfile (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_we    (WB_we),
        .i_waddr (WB_addr),
        .i_wdata (WB_data),
        .i_ra1   (Ra1),
        .i_ra2   (Ra2),
        .o_rd1   (Rdata1),
        .o_rd2   (Rdata2)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!Stall) begin
            case (w_kind)
                WB_HILO: begin
                    r_hi <= HI_in;
                    r_lo <= LO_in;
                end
                WB_MTHI: r_hi <= Wdata;
                WB_MTLO: r_lo <= Wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wcount <= '0;
        end else if (WB_we) begin
            r_wcount <= r_wcount + 32'd1;
        end
    end

    assign HI     = r_hi;
    assign LO     = r_lo;
    assign Wcount = r_wcount;

endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - scoreboard bench for wb_unit with a behavioural register model
module tb_wb_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] Ins = '0, Wdata = '0, nextPC = '0, HI_in = '0, LO_in = '0;
    logic        Stall = 1'b0;
    logic [4:0]  Ra1 = '0, Ra2 = '0;
    logic [31:0] Rdata1, Rdata2, HI, LO, WB_data, Wcount;
    logic        WB_we;
    logic [4:0]  WB_addr;

    wb_unit dut (
        .CLK(CLK), .RST(RST), .Ins(Ins), .Wdata(Wdata), .nextPC(nextPC),
        .HI_in(HI_in), .LO_in(LO_in), .Stall(Stall), .Ra1(Ra1), .Ra2(Ra2),
        .Rdata1(Rdata1), .Rdata2(Rdata2), .HI(HI), .LO(LO), .WB_we(WB_we),
        .WB_addr(WB_addr), .WB_data(WB_data), .Wcount(Wcount)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Architectural model
    logic [31:0] m_reg [32];
    logic [31:0] m_hi, m_lo, m_wc;

    typedef struct { logic [4:0] addr; logic [31:0] data; } commit_t;
    commit_t exp_q[$];

    // Effect predicted for the instruction currently presented
    logic        p_gpr;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic        p_hi_we, p_lo_we;
    logic [31:0] p_hi, p_lo;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_hi = '0; m_lo = '0; m_wc = '0;
    endtask

    // Reference decode: classifies by the instruction-set rules using numeric codes
    task automatic predict(input logic [31:0] ins, input logic [31:0] wd, input logic [31:0] npc,
                           input logic [31:0] hin, input logic [31:0] lin, input logic stl);
        int op, fn;
        logic        gw;
        logic [4:0]  d;
        logic [31:0] v;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        gw = 1'b0; d = '0; v = '0;
        p_hi_we = 1'b0; p_lo_we = 1'b0; p_hi = '0; p_lo = '0;
        if (op == 0) begin
            if (fn inside {32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 16, 18}) begin
                gw = 1'b1; d = ins[15:11]; v = wd;
            end else if (fn == 9) begin
                gw = 1'b1; d = ins[15:11]; v = npc;
            end else if (fn >= 24 && fn <= 27) begin
                p_hi_we = 1'b1; p_lo_we = 1'b1; p_hi = hin; p_lo = lin;
            end else if (fn == 17) begin
                p_hi_we = 1'b1; p_hi = wd;
            end else if (fn == 19) begin
                p_lo_we = 1'b1; p_lo = wd;
            end
        end else if ((op >= 8 && op <= 15) || op == 35) begin
            gw = 1'b1; d = ins[20:16]; v = wd;
        end else if (op == 3) begin
            gw = 1'b1; d = 5'd31; v = npc;
        end
        if (stl) begin
            gw = 1'b0; p_hi_we = 1'b0; p_lo_we = 1'b0;
        end
        p_gpr  = gw && (d != 0);
        p_addr = d;
        p_data = v;
    endtask

    // Presents one instruction for one clock edge and checks the architectural state after it
    task automatic step(input logic [31:0] ins, input logic [31:0] wd, input logic [31:0] npc,
                        input logic [31:0] hin, input logic [31:0] lin, input logic stl);
        commit_t c;
        logic [31:0] r;
        Ins = ins; Wdata = wd; nextPC = npc; HI_in = hin; LO_in = lin; Stall = stl;
        predict(ins, wd, npc, hin, lin, stl);
        if (p_gpr) begin
            c.addr = p_addr; c.data = p_data;
            exp_q.push_back(c);
        end
        // Before the edge the destination still shows its old value
        Ra1 = p_addr;
        #1;
        chk("pre_edge_read", Rdata1, m_reg[p_addr]);
        @(posedge CLK);
        if (p_gpr) begin
            m_reg[p_addr] = p_data;
            m_wc = m_wc + 32'd1;
        end
        if (p_hi_we) m_hi = p_hi;
        if (p_lo_we) m_lo = p_lo;
        #1;
        r = $urandom();
        Ra1 = p_addr;
        Ra2 = r[4:0];
        #1;
        chk("rdata1", Rdata1, m_reg[Ra1]);
        chk("rdata2", Rdata2, m_reg[Ra2]);
        chk("hi", HI, m_hi);
        chk("lo", LO, m_lo);
        chk("wcount", Wcount, m_wc);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        logic [5:0]  op, fn;
        logic [5:0]  rfn [18];
        logic [5:0]  oth [5];
        int k;
        rfn = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42,
                6'd43, 6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd16, 6'd18};
        oth = '{6'd43, 6'd4, 6'd5, 6'd2, 6'd63};
        r  = $urandom();
        op = 6'd0;
        fn = r[5:0];
        k  = int'($urandom_range(0, 9));
        case (k)
            0: fn = rfn[$urandom_range(0, 17)];
            1: fn = 6'd9;
            2: fn = 6'd8;
            3: fn = 6'(24 + $urandom_range(0, 3));
            4: fn = 6'd17;
            5: fn = 6'd19;
            6: op = 6'(8 + $urandom_range(0, 7));
            7: op = 6'd35;
            8: op = 6'd3;
            default: op = oth[$urandom_range(0, 4)];
        endcase
        // Small destination fields so $0 and rewrites of the same register are common
        return {op, r[25:21], 2'b00, r[18:16], 2'b00, r[13:11], r[10:6], fn};
    endfunction

    // Monitor: whenever the DUT announces a commit, it must be the next one expected
    always @(negedge CLK) begin
        if (RST && WB_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_commit actual addr=%0d data=%h expected none", WB_addr, WB_data);
            end else begin
                commit_t e;
                e = exp_q.pop_front();
                chk("commit_addr", {27'b0, WB_addr}, {27'b0, e.addr});
                chk("commit_data", WB_data, e.data);
            end
        end
    end

    task automatic mid_cycle_reset();
        Ins = 32'h0; Stall = 1'b0;
        Ra1 = 5'd31; Ra2 = 5'd3;
        RST = 1'b0;
        #1;
        chk("rst_rdata1", Rdata1, 32'h0);
        chk("rst_rdata2", Rdata2, 32'h0);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        chk("rst_wcount", Wcount, 32'h0);
        model_clear();
        exp_q.delete();
        // A writing instruction during reset must be ignored
        Ins = 32'h00221820; Wdata = 32'h12345678;
        @(posedge CLK);
        #1;
        Ins = 32'h0;
        @(negedge CLK);
        #2;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_hold_reg3", Rdata2, 32'h0);
    endtask

    initial begin
        logic [31:0] ins, wd, npc, hin, lin;
        model_clear();
        #1;
        chk("init_rdata1", Rdata1, 32'h0);
        chk("init_hi", HI, 32'h0);
        chk("init_lo", LO, 32'h0);
        chk("init_wcount", Wcount, 32'h0);
        #12;
        RST = 1'b1;
        @(posedge CLK);
        #1;

        step(32'h00221820, 32'h00000007, 32'h0, 32'h0, 32'h0, 1'b0);  // ADD $3
        step(32'h20000005, 32'h00000005, 32'h0, 32'h0, 32'h0, 1'b0);  // ADDI $0
        step(32'h0C000010, 32'h55555555, 32'h00000044, 32'h0, 32'h0, 1'b0);  // JAL
        step(32'hAC030000, 32'h66666666, 32'h0, 32'h0, 32'h0, 1'b0);  // SW
        step(32'h00220018, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFE, 1'b0);  // MULT
        step(32'h00200013, 32'hABCD0000, 32'h0, 32'h0, 32'h0, 1'b0);  // MTLO
        for (int i = 0; i < 3; i++)
            step(32'h8C040000, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1'b1);  // LW stalled
        step(32'h8C040000, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1'b0);
        Ra1 = 5'd4;
        #1;
        chk("lw_after_stall", Rdata1, 32'hDEADBEEF);
        chk("lw_wcount", Wcount, 32'd3);

        for (int i = 0; i < 300; i++) begin
            ins = rand_ins(); wd = $urandom(); npc = $urandom();
            hin = $urandom(); lin = $urandom();
            step(ins, wd, npc, hin, lin, $urandom_range(0, 3) == 0);
        end

        mid_cycle_reset();

        for (int i = 0; i < 60; i++) begin
            ins = rand_ins(); wd = $urandom(); npc = $urandom();
            hin = $urandom(); lin = $urandom();
            step(ins, wd, npc, hin, lin, $urandom_range(0, 3) == 0);
        end

        @(negedge CLK);
        chk("pending_commits", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
